// File: rtl/updi_phy_tx.sv
// UPDI physical-layer transmitter: frame FIFO, format check and LSB-first serializer
// with a post-frame guard period that keeps the line driver enabled.
module updi_phy_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned GUARD_BITS   = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [11:0]                   i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_tx_en,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_frame_err
);

   localparam int unsigned AW           = $clog2(FIFO_DEPTH);
   localparam int unsigned GUARD_CYCLES = GUARD_BITS * CLKS_PER_BIT;
   localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
   localparam logic [23:0] GUARD_LAST   = (GUARD_CYCLES == 0) ? 24'd0 : 24'(GUARD_CYCLES - 1);
   localparam logic [AW:0] PTR_ONE      = (AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StShift, StGuard} state_e;

   state_e      state_q, state_d;
   logic [11:0] shreg_q, shreg_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [23:0] guard_cnt_q, guard_cnt_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        frame_err_q, frame_err_d;
   logic [11:0] fifo_mem_q [FIFO_DEPTH];

   logic        empty, full, accept, frame_ok, push, pop;
   logic [11:0] head;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head     = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign o_ready  = !full && !i_rst;
   assign accept   = i_valid && o_ready;
   assign frame_ok = (i_data[0] == 1'b0) && (i_data[11:10] == 2'b11) &&
                     ((^i_data[8:1]) == i_data[9]);
   assign push     = accept && frame_ok;

   assign o_count     = wr_ptr_q - rd_ptr_q;
   assign o_frame_err = frame_err_q;
   assign o_busy      = (state_q != StIdle);
   assign o_tx_en     = (state_q != StIdle);
   assign o_tx        = (state_q == StShift) ? shreg_q[0] : 1'b1;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      frame_err_d = accept && !frame_ok;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      guard_cnt_d = guard_cnt_q;
      pop         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop       = 1'b1;
               shreg_d   = head;
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               shreg_d   = {1'b1, shreg_q[11:1]};
               if (bit_idx_q == 4'd11) begin
                  bit_idx_d = '0;
                  // Chain straight into the next frame so the line never idles between frames.
                  if (!empty) begin
                     pop     = 1'b1;
                     shreg_d = head;
                  end else if (GUARD_BITS > 0) begin
                     guard_cnt_d = '0;
                     state_d     = StGuard;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         StGuard: begin
            if (!empty) begin
               pop       = 1'b1;
               shreg_d   = head;
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = StShift;
            end else if (guard_cnt_q == GUARD_LAST) begin
               state_d = StIdle;
            end else begin
               guard_cnt_d = guard_cnt_q + 24'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         shreg_q     <= '1;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         guard_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         guard_cnt_q <= guard_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: tb/tb_updi_phy_tx.sv
// Directed bench for updi_phy_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8, GUARD_BITS=2.
module tb_updi_phy_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned GBITS = 2;

   logic        i_clk;
   logic        i_rst;
   logic [11:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic        o_tx;
   logic        o_tx_en;
   logic        o_busy;
   logic [3:0]  o_count;
   logic        o_frame_err;

   int n_cmp = 0;
   int n_err = 0;

   updi_phy_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .GUARD_BITS   (GBITS)
   ) u_dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_tx        (o_tx),
      .o_tx_en     (o_tx_en),
      .o_busy      (o_busy),
      .o_count     (o_count),
      .o_frame_err (o_frame_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_frame(input logic [11:0] f, input int first);
      for (int i = first; i < 12 * CPB; i++) begin
         chk("tx_bit", 32'(o_tx), 32'(f[i / CPB]));
         chk("tx_en_frame", 32'(o_tx_en), 32'd1);
         tick();
      end
   endtask

   task automatic expect_guard(input int n);
      for (int i = 0; i < n; i++) begin
         chk("guard_tx", 32'(o_tx), 32'd1);
         chk("guard_en", 32'(o_tx_en), 32'd1);
         tick();
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 1000) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(o_busy), 32'd0);
   endtask

   logic [11:0] bad_frames [3];
   int          n_wait;
   int          en_hits;

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      bad_frames[0] = 12'hCAB;
      bad_frames[1] = 12'hEAA;
      bad_frames[2] = 12'h4AA;

      // Reset
      repeat (3) tick();
      chk("rst_tx", 32'(o_tx), 32'd1);
      chk("rst_en", 32'(o_tx_en), 32'd0);
      chk("rst_cnt", 32'(o_count), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_err", 32'(o_frame_err), 32'd0);
      i_rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(o_ready), 32'd1);
      tick();

      // Single SYNCH frame
      i_valid = 1'b1;
      i_data  = 12'hCAA;
      chk("s2_ready", 32'(o_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      chk("s2_cnt", 32'(o_count), 32'd1);
      chk("s2_pre_tx", 32'(o_tx), 32'd1);
      chk("s2_pre_en", 32'(o_tx_en), 32'd0);
      tick();
      chk("s2_cnt_pop", 32'(o_count), 32'd0);
      expect_frame(12'hCAA, 0);
      expect_guard(GBITS * CPB);
      chk("s2_end_en", 32'(o_tx_en), 32'd0);
      chk("s2_end_busy", 32'(o_busy), 32'd0);
      chk("s2_end_tx", 32'(o_tx), 32'd1);

      // Back-to-back frames
      i_valid = 1'b1;
      i_data  = 12'hCAA;
      tick();
      chk("b2b_cnt0", 32'(o_count), 32'd1);
      i_data = 12'hD40;
      tick();
      chk("b2b_cnt1", 32'(o_count), 32'd1);
      chk("b2b_start", 32'(o_tx), 32'd0);
      i_data = 12'hCCC;
      tick();
      i_valid = 1'b0;
      chk("b2b_cnt2", 32'(o_count), 32'd2);
      expect_frame(12'hCAA, 1);
      expect_frame(12'hD40, 0);
      expect_frame(12'hCCC, 0);
      expect_guard(4);
      chk("g5_tx", 32'(o_tx), 32'd1);
      chk("g5_en", 32'(o_tx_en), 32'd1);
      i_valid = 1'b1;
      i_data  = 12'hD40;
      tick();
      i_valid = 1'b0;
      chk("g6_tx", 32'(o_tx), 32'd1);
      chk("g6_en", 32'(o_tx_en), 32'd1);
      chk("g6_cnt", 32'(o_count), 32'd1);
      tick();
      expect_frame(12'hD40, 0);
      expect_guard(GBITS * CPB);
      chk("b2b_end_en", 32'(o_tx_en), 32'd0);
      wait_idle();

      // Full FIFO
      for (int k = 0; k < 9; k++) begin
         i_valid = 1'b1;
         i_data  = 12'hCAA;
         chk("full_fill_ready", 32'(o_ready), 32'd1);
         tick();
      end
      chk("full_cnt8", 32'(o_count), 32'd8);
      chk("full_ready0", 32'(o_ready), 32'd0);
      n_wait = 0;
      while (!o_ready && n_wait < 100) begin
         chk("full_hold_cnt", 32'(o_count), 32'd8);
         tick();
         n_wait++;
      end
      chk("full_wait", 32'(n_wait), 32'd41);
      chk("full_cnt7", 32'(o_count), 32'd7);
      tick();
      i_valid = 1'b0;
      chk("full_refill", 32'(o_count), 32'd8);
      chk("full_ready_again", 32'(o_ready), 32'd0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("flush_cnt", 32'(o_count), 32'd0);
      tick();

      // Malformed frames
      for (int b = 0; b < 3; b++) begin
         i_valid = 1'b1;
         i_data  = bad_frames[b];
         tick();
         i_valid = 1'b0;
         chk("bad_err_pulse", 32'(o_frame_err), 32'd1);
         chk("bad_cnt", 32'(o_count), 32'd0);
         tick();
         chk("bad_err_clear", 32'(o_frame_err), 32'd0);
         chk("bad_busy", 32'(o_busy), 32'd0);
         chk("bad_en", 32'(o_tx_en), 32'd0);
         tick();
      end

      // Reset mid-frame
      i_valid = 1'b1;
      i_data  = 12'hCAA;
      tick();
      i_data = 12'hD40;
      tick();
      i_data = 12'hCCC;
      tick();
      i_data = 12'hCAA;
      tick();
      i_valid = 1'b0;
      chk("mid_cnt3", 32'(o_count), 32'd3);
      repeat (19) tick();
      chk("mid_bit5", 32'(o_tx), 32'd1);
      chk("mid_en", 32'(o_tx_en), 32'd1);
      i_rst = 1'b1;
      #1;
      chk("mid_ready0", 32'(o_ready), 32'd0);
      tick();
      chk("mid_rst_tx", 32'(o_tx), 32'd1);
      chk("mid_rst_en", 32'(o_tx_en), 32'd0);
      chk("mid_rst_cnt", 32'(o_count), 32'd0);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      i_rst   = 1'b0;
      en_hits = 0;
      for (int c = 0; c < 100; c++) begin
         if (o_tx_en) en_hits++;
         tick();
      end
      chk("mid_no_resume", 32'(en_hits), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
